aes_key_expand: RTL

AES_KEY_EXPAND -- requirements
Module: aes_key_expand

---
 rtl/aes_pkg.sv | 8 +
 rtl/sbox.sv | 24 ++
 rtl/sub_word.sv | 11 +
 rtl/aes_key_expand.sv | 84 ++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared types and constants for the AES-128 key expander
package aes_pkg;
  typedef enum logic {IDLE, RUN} state_e;
  typedef logic [31:0] word_t;
  localparam int NR = 10;
  localparam logic [7:0] RCON [12] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36, 8'h00};
endpackage

// File: rtl/sbox.sv
// sbox: AES forward S-box, one byte in, one byte out
module sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};
  assign o_byte = SBOX[i_byte];
endmodule

// File: rtl/sub_word.sv
// sub_word: AES SubWord, the forward S-box applied to each byte of a word
module sub_word
  import aes_pkg::*;
(
  input  word_t i_word,
  output word_t o_word
);
  for (genvar i = 0; i < 4; i++) begin : g_sb
    sbox u_sbox (.i_byte(i_word[8*i +: 8]), .o_byte(o_word[8*i +: 8]));
  end
endmodule

// File: rtl/aes_key_expand.sv
// aes_key_expand: iterative AES-128 key schedule with valid/ready round-key output; AES_RKEY_STORE_EN adds an 11-entry readable round-key store
module aes_key_expand
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         done
`ifdef AES_RKEY_STORE_EN
  ,
  input  logic [3:0]   rk_rd_idx,
  output logic [127:0] rk_rd_data
`endif
);
  state_e       r_state, w_state_nxt;
  logic [127:0] r_key;
  logic [7:0]   r_rcon;
  logic [3:0]   r_round;
  logic         r_valid, r_done;
  word_t        w_sub, w4, w5, w6, w7;
  logic         w_accept, w_hs, w_last;
  assign w_accept = (r_state == IDLE) && start;
  assign w_hs     = r_valid && rk_ready;
  assign w_last   = w_hs && (r_round == 4'(NR));
  sub_word u_sub (.i_word({r_key[23:0], r_key[31:24]}), .o_word(w_sub));
  assign w4 = r_key[127:96] ^ w_sub ^ {r_rcon, 24'h0};
  assign w5 = r_key[95:64] ^ w4;
  assign w6 = r_key[63:32] ^ w5;
  assign w7 = r_key[31:0] ^ w6;
  // state register
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_state_nxt;
  // leave IDLE on start, return after the final round key is taken
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = w_accept ? RUN : w_last ? IDLE : r_state;
  end
  // round key, Rcon and round counter; the key register is zeroed whenever no key is valid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key   <= '0;
      r_rcon  <= '0;
      r_round <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_key   <= key_in;
        r_rcon  <= RCON[1];
        r_round <= '0;
        r_valid <= 1'b1;
      end else if (w_last) begin
        r_key   <= '0;
        r_rcon  <= '0;
        r_round <= '0;
        r_valid <= 1'b0;
      end else if (w_hs) begin
        r_key   <= {w4, w5, w6, w7};
        r_rcon  <= RCON[r_round + 4'd2];
        r_round <= r_round + 4'd1;
      end
    end
  end
  assign busy     = (r_state == RUN);
  assign rk_valid = r_valid;
  assign rk_out   = r_valid ? r_key : '0;
  assign rk_round = r_round;
  assign done     = r_done;
`ifdef AES_RKEY_STORE_EN
  logic [127:0] r_store [11];
  // capture each round key as it is handed off
  always_ff @(posedge clk) begin
    if (rst) r_store <= '{default: '0};
    else if (w_hs) r_store[r_round] <= r_key;
  end
  assign rk_rd_data = (rk_rd_idx <= 4'(NR)) ? r_store[rk_rd_idx] : '0;
`endif
endmodule
